puf_resp_collector: RTL and testbench
=====================================

# puf_resp_collector

Sequencer and sampler that sits directly downstream of the 128:1 PUF output mux. It drives the mux select across all 128 cells, waits a settle interval, majority-votes repeated samples of the mux output, and assembles a 128-bit PUF response with a ones-count health figure. It is controlled by a start/busy/done handshake from the PUF control logic.

## Interface
- SETTLE_CYC, 2: cycles waited after each select change before sampling; legal range 1..15.
- VOTE_N, 3: samples taken per bit for majority vote; odd, legal range 1..15.
- i_Clk  in  1  clock; all logic is rising-edge.
- i_Rst  in  1  synchronous reset, active-high.
- i_Start  in  1  request a full 128-bit collection; sampled only in IDLE.
- o_Sel  out  7  select to the mux (bit index being read).
- i_Q  in  1  selected mux output.
- o_Busy  out  1  high while a collection is in progress.
- o_Done  out  1  single-cycle pulse; o_Resp and o_Ones are updated in this cycle.
- o_Resp  out  128  last completed response; bit i is the voted value for select i.
- o_Ones  out  8  population count of o_Resp, 0..128.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, STORE, DONE.
- IDLE: o_Sel=0, o_Busy=0. i_Start=1 -> sel=0, settle counter cleared, vote counter cleared -> SETTLE.
- SETTLE: count SETTLE_CYC cycles with o_Sel stable; i_Q ignored -> SAMPLE.
- SAMPLE: exactly VOTE_N consecutive cycles; each cycle adds i_Q to the ones accumulator (width $clog2(VOTE_N+1)) -> STORE.
- STORE: one cycle. bit = (ones accumulator > VOTE_N/2, integer division). Written into internal shadow register at position sel. Running popcount is incremented by bit. Accumulator cleared. If sel==127 -> DONE; else sel+1 -> SETTLE.
- DONE: one cycle. o_Done=1, o_Busy=0. o_Resp <= shadow, o_Ones <= running popcount. -> IDLE.
- o_Resp/o_Ones hold the previous result for the whole of a collection; they change only in the DONE cycle and never show partial data.
- i_Start outside IDLE (SETTLE/SAMPLE/STORE/DONE) is ignored, not queued.
- Popcount is 8 bits; max 128 (0x80), no overflow possible.
- Reset mid-operation: the next cycle shows IDLE; o_Sel=0, o_Busy=0, o_Done=0, o_Resp=0, o_Ones=0, shadow/popcount/counters cleared. No partial result is published.

## Timing
- Reset values: o_Sel=0, o_Busy=0, o_Done=0, o_Resp=0, o_Ones=0.
- i_Start high at edge k in IDLE -> o_Busy=1 and o_Sel=0 from cycle k+1.
- Per-bit period P = SETTLE_CYC + VOTE_N + 1 cycles; o_Sel increments on the edge that leaves STORE.
- o_Done high in cycle k+1+128*P (defaults: P=6, cycle k+769). Earliest next accepted i_Start is at k+2+128*P.
- o_Sel is registered and is stable for the full P cycles of each bit.
- i_Q is sampled only during the VOTE_N SAMPLE cycles. i_Q during SETTLE, STORE, IDLE or DONE has no effect.

## Test plan
- Reset: assert i_Rst 2 cycles with random i_Q/i_Start -> all outputs 0. o_Sel stays 0 in IDLE.
- Golden pattern: bench mux model i_Q=D[o_Sel] with D=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210. Pulse i_Start at k -> o_Done exactly at k+769; o_Resp==D; o_Ones==64. o_Done is high for 1 cycle.
- Majority vote (VOTE_N=3): in every bit's SAMPLE window, invert i_Q for 1 of 3 cycles -> o_Resp==D. Invert 2 of 3 cycles for bit 5 only -> o_Resp==D^(1<<5). Inverting i_Q throughout SETTLE -> no effect.
- All-ones / all-zeros: D=all 1s -> o_Ones==128. Then D=0 -> o_Ones==0 and o_Resp==0, with the prior all-ones value held until the second o_Done.
- Start while busy: second i_Start pulses at k+10 and in the DONE cycle -> exactly one o_Done. o_Busy drops in the DONE cycle and o_Busy=0 afterwards.
- Reset mid-run: assert i_Rst while o_Sel==50 -> next cycle all outputs 0. A fresh i_Start then yields the full correct D at the nominal latency.

Source files
------------

// File: rtl/puf_resp_collector.sv
//============================================================================
// puf_resp_collector : steps the 128:1 PUF mux, settles, majority-votes each
// bit and publishes a 128-bit response with its ones-count.   Rev 1.0
//============================================================================
`default_nettype none

module puf_resp_collector #(
  parameter int SETTLE_CYC = 2,
  parameter int VOTE_N     = 3
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  output logic [6:0]   o_Sel,
  input  logic         i_Q,
  output logic         o_Busy,
  output logic         o_Done,
  output logic [127:0] o_Resp,
  output logic [7:0]   o_Ones
);

  localparam int ACC_W = $clog2(VOTE_N + 1);
  localparam logic [ACC_W-1:0] c_VOTE_HALF   = ACC_W'(VOTE_N / 2);
  localparam logic [3:0]       c_SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]       c_VOTE_LAST   = 4'(VOTE_N - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_STORE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q,  state_d;
  logic [6:0]         sel_q,    sel_d;
  logic [3:0]         cnt_q,    cnt_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic [127:0]       shadow_q, shadow_d;
  logic [7:0]         pop_q,    pop_d;
  logic [127:0]       resp_q,   resp_d;
  logic [7:0]         ones_q,   ones_d;
  logic               w_vote_bit;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    shadow_d   = shadow_q;
    pop_d      = pop_q;
    resp_d     = resp_q;
    ones_d     = ones_q;
    w_vote_bit = (acc_q > c_VOTE_HALF);

    case (state_q)
      S_IDLE: begin
        sel_d = '0;
        cnt_d = '0;
        acc_d = '0;
        if (i_Start) begin
          shadow_d = '0;
          pop_d    = '0;
          state_d  = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == c_SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        acc_d = acc_q + ACC_W'(i_Q);
        if (cnt_q == c_VOTE_LAST) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_STORE: begin
        shadow_d[sel_q] = w_vote_bit;
        pop_d           = pop_q + {7'd0, w_vote_bit};
        acc_d           = '0;
        // Publish on entry to DONE so the new result is visible with o_Done.
        if (sel_q == 7'd127) begin
          resp_d  = shadow_d;
          ones_d  = pop_d;
          state_d = S_DONE;
        end else begin
          sel_d   = sel_q + 7'd1;
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        sel_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      pop_q    <= '0;
      resp_q   <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      pop_q    <= pop_d;
      resp_q   <= resp_d;
      ones_q   <= ones_d;
    end
  end

  assign o_Sel  = sel_q;
  assign o_Busy = (state_q == S_SETTLE) || (state_q == S_SAMPLE) || (state_q == S_STORE);
  assign o_Done = (state_q == S_DONE);
  assign o_Resp = resp_q;
  assign o_Ones = ones_q;

endmodule

`default_nettype wire

// File: tb/tb_puf_resp_collector.sv
//============================================================================
// tb_puf_resp_collector : directed bench with a cycle-level reference model
// of the collection schedule and majority vote.   Rev 1.0
//============================================================================
`default_nettype none

module tb_puf_resp_collector;

  localparam int SETTLE_CYC = 2;
  localparam int VOTE_N     = 3;
  localparam int P          = SETTLE_CYC + VOTE_N + 1;
  localparam int RUN        = 128 * P;
  localparam logic [127:0] c_D = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         q;
  logic [6:0]   sel;
  logic         busy;
  logic         done;
  logic [127:0] resp;
  logic [7:0]   ones;

  always #5 clk = ~clk;

  puf_resp_collector #(
    .SETTLE_CYC (SETTLE_CYC),
    .VOTE_N     (VOTE_N)
  ) u_dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Start (start),
    .o_Sel   (sel),
    .i_Q     (q),
    .o_Busy  (busy),
    .o_Done  (done),
    .o_Resp  (resp),
    .o_Ones  (ones)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: run bookkeeping in whole cycles since the start edge.
  bit           m_active = 1'b0;
  int           m_k      = 0;
  int           t        = 0;
  logic [127:0] m_exp    = '0;
  logic [127:0] m_resp   = '0;
  logic [7:0]   m_ones   = '0;

  // Mux contents and disturbance pattern for the current run.
  logic [127:0] d          = '0;
  int           inv_all    = 0;
  int           inv_b5     = -1;
  bit           inv_settle = 1'b0;
  bit           start_on_done = 1'b0;

  int done_cnt      = 0;
  int last_done_cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
  endtask

  function automatic int popc(input logic [127:0] v);
    int c = 0;
    for (int i = 0; i < 128; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int n_inv(input int i);
    return (i == 5 && inv_b5 >= 0) ? inv_b5 : inv_all;
  endfunction

  // A bit reads back inverted only when the inverted samples win the vote.
  function automatic logic [127:0] expect_resp();
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = d[i] ^ (n_inv(i) > VOTE_N / 2);
    return r;
  endfunction

  task automatic step(input bit r, input bit s, input bit chk_en);
    int  n;
    int  ph;
    bit  done_now;
    @(negedge clk);
    n = t - m_k;
    if (chk_en) begin
      if (!m_active) begin
        chk("busy", busy, 0);
        chk("done", done, 0);
        chk("sel",  sel,  0);
      end else if (n < RUN) begin
        chk("busy", busy, 1);
        chk("done", done, 0);
        chk("sel",  sel,  128'(n / P));
      end else begin
        chk("busy", busy, 0);
        chk("done", done, 1);
      end
      chk("resp", resp, m_resp);
      chk("ones", ones, m_ones);
    end
    done_now = (done === 1'b1);
    if (done_now) begin
      done_cnt++;
      last_done_cyc = t + 1;
    end

    rst   = r;
    start = s | (start_on_done & done_now);
    q     = 1'($urandom_range(0, 1));
    if (m_active && n < RUN) begin
      ph = n % P;
      if (ph < SETTLE_CYC) begin
        if (inv_settle) q = ~d[sel];
      end else if (ph < SETTLE_CYC + VOTE_N) begin
        q = d[sel] ^ ((ph - SETTLE_CYC) < n_inv(n / P));
      end
    end

    if (r) begin
      m_active = 1'b0;
      m_resp   = '0;
      m_ones   = '0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_k      = t + 1;
        m_exp    = expect_resp();
      end
    end else if (n == RUN - 1) begin
      m_resp = m_exp;
      m_ones = 8'(popc(m_exp));
    end else if (n == RUN) begin
      m_active = 1'b0;
    end
    t++;
  endtask

  // One collection; abort_sel >= 0 asserts reset when that bit is selected.
  task automatic run(input bit extra, input int abort_sel, output int k);
    int dc0;
    bit r;
    bit ended;
    dc0   = done_cnt;
    ended = 1'b0;
    step(0, 1, 1);
    k = m_k;
    for (int c = 0; c < RUN + 10 && !ended; c++) begin
      r = (abort_sel >= 0) && m_active && ((t - m_k) / P == abort_sel);
      step(r, extra && (t == k + 9), 1);
      if (r) return;
      if (done_cnt != dc0) ended = 1'b1;
    end
    if (!ended) chk("done_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  initial begin
    int k;
    int dc0;
    rst   = 1'b1;
    start = 1'b0;
    q     = 1'b0;

    step(1, 1'($urandom_range(0, 1)), 0);
    step(1, 1'($urandom_range(0, 1)), 1);
    idle(4);
    chk("reset_resp", resp, 0);
    chk("reset_ones", ones, 0);
    chk("reset_sel",  sel,  0);

    // Clean golden pattern
    d = c_D;
    run(0, -1, k);
    chk("golden_latency", last_done_cyc - k, 769);
    idle(1);
    chk("golden_resp", resp, c_D);
    chk("golden_ones", ones, 64);

    // One of three samples inverted on every bit
    inv_all = 1;
    run(0, -1, k);
    idle(2);
    chk("vote1of3_resp", resp, c_D);

    // Two of three inverted on bit 5 only
    inv_b5 = 2;
    run(0, -1, k);
    idle(2);
    chk("vote2of3_resp", resp, c_D ^ (128'd1 << 5));
    chk("vote2of3_ones", ones, 65);

    // Settle-window disturbance must not matter
    inv_all = 0; inv_b5 = -1; inv_settle = 1'b1;
    run(0, -1, k);
    idle(2);
    chk("settle_inv_resp", resp, c_D);
    inv_settle = 1'b0;

    // All ones then all zeros
    d = '1;
    run(0, -1, k);
    idle(2);
    chk("all1_ones", ones, 128);
    chk("all1_resp", resp, {128{1'b1}});
    d = '0;
    run(0, -1, k);
    idle(2);
    chk("all0_ones", ones, 0);
    chk("all0_resp", resp, 0);

    // Start pulses while busy and in the DONE cycle
    d = c_D;
    dc0 = done_cnt;
    start_on_done = 1'b1;
    run(1, -1, k);
    start_on_done = 1'b0;
    idle(P * 3);
    chk("busy_start_done_count", done_cnt - dc0, 1);
    chk("busy_start_latency", last_done_cyc - k, 769);
    chk("busy_start_busy_after", busy, 0);

    // Reset while bit 50 is selected, then a fresh run
    dc0 = done_cnt;
    run(0, 50, k);
    step(0, 0, 1);
    chk("midrst_resp", resp, 0);
    chk("midrst_sel",  sel,  0);
    chk("midrst_no_done", done_cnt - dc0, 0);
    idle(2);
    run(0, -1, k);
    idle(2);
    chk("post_rst_latency", last_done_cyc - k, 769);
    chk("post_rst_resp", resp, c_D);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
